serial_parity_checker: RTL and testbench



---
 rtl/uart_parity_pkg.sv | 29 ++
 rtl/sat_counter.sv | 32 +++
 rtl/serial_parity_checker.sv | 156 +++++++++++++++
 tb/tb_serial_parity_checker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_parity_pkg.sv
// Shared definitions for the UART serial parity checker: parity modes, FSM encoding,
// legal data-width bounds and the per-mode parity helper.
package uart_parity_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;
   localparam logic [1:0] PAR_MARK = 2'b11;

   localparam int DATA_WIDTH_MIN = 5;
   localparam int DATA_WIDTH_MAX = 9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   function automatic logic mode_parity(input logic [1:0] mode, input logic data_xor);
      case (mode)
         PAR_EVEN: return data_xor;
         PAR_ODD:  return ~data_xor;
         PAR_MARK: return 1'b1;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a coincident clear and increment yields 1.
// EN=0 removes the counter entirely and ties count to zero.
module sat_counter #(
   parameter int WIDTH = 8,
   parameter bit EN    = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   generate
      if (EN) begin : g_cnt
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               count <= '0;
            end else if (clr) begin
               count <= inc ? WIDTH'(1) : '0;
            end else if (inc && (count != '1)) begin
               count <= count + WIDTH'(1);
            end
         end
      end else begin : g_tied
         logic unused_inputs;
         assign unused_inputs = &{1'b0, clk, rst_n, clr, inc};
         assign count         = '0;
      end
   endgenerate

endmodule

// File: rtl/serial_parity_checker.sv
// Bit-serial UART parity checker: LSB-first data, optional parity bit, per-frame result.
// Define SERIAL_PARITY_ERR_CNT_EN to build the saturating err_count; otherwise it reads 0.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for start; bit_valid ignored
// ST_DATA   | shifting in DATA_WIDTH data bits, accumulating parity
// ST_PARITY | waiting for the received parity bit
// ST_DONE   | one-cycle result pulse, then back to IDLE (or DATA on start)
module serial_parity_checker
   import uart_parity_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            parity_mode,
   input  logic                  bit_valid,
   input  logic                  bit_in,
   output logic                  busy,
   output logic                  result_valid,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  calc_parity,
   output logic                  parity_ok,
   output logic                  parity_err,
   input  logic                  clr_err,
   output logic [CNT_WIDTH-1:0]  err_count
);

   localparam int BCW = $clog2(DATA_WIDTH_MAX + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

   generate
      if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
         $error("serial_parity_checker: DATA_WIDTH out of legal range");
      end
   endgenerate

   state_t                state, next_state;
   logic [1:0]            mode_q;
   logic                  acc;
   logic [BCW-1:0]        bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg, shift_next, word_final;
   logic                  acc_final, calc_next, ok_next;
   logic                  frame_end, err_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      frame_end  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) next_state = ST_DATA;
         end
         ST_DATA: begin
            if (start) begin
               next_state = ST_DATA;
            end else if (bit_valid && (bit_cnt == LAST_BIT)) begin
               if (mode_q == PAR_NONE) begin
                  next_state = ST_DONE;
                  frame_end  = 1'b1;
               end else begin
                  next_state = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (start) begin
               next_state = ST_DATA;
            end else if (bit_valid) begin
               next_state = ST_DONE;
               frame_end  = 1'b1;
            end
         end
         ST_DONE: begin
            next_state = start ? ST_DATA : ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // The final bit may be the last data bit (none mode), so fold it in before the compare.
   always_comb begin
      shift_next = {bit_in, shift_reg[DATA_WIDTH-1:1]};
      acc_final  = acc;
      word_final = shift_reg;
      if (state == ST_DATA) begin
         acc_final  = acc ^ bit_in;
         word_final = shift_next;
      end
      calc_next = mode_parity(mode_q, acc_final);
      ok_next   = (mode_q == PAR_NONE) || (bit_in == calc_next);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= PAR_NONE;
         acc         <= 1'b0;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         data_out    <= '0;
         calc_parity <= 1'b0;
         parity_ok   <= 1'b1;
      end else begin
         if (start) begin
            mode_q    <= parity_mode;
            acc       <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
         end else if (bit_valid && (state == ST_DATA)) begin
            shift_reg <= shift_next;
            acc       <= acc ^ bit_in;
            bit_cnt   <= bit_cnt + BCW'(1);
         end
         if (frame_end) begin
            data_out    <= word_final;
            calc_parity <= calc_next;
            parity_ok   <= ok_next;
         end
      end
   end

   assign busy         = (state == ST_DATA) || (state == ST_PARITY);
   assign result_valid = (state == ST_DONE);
   assign err_evt      = result_valid && !parity_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       parity_err <= 1'b0;
      else if (clr_err) parity_err <= err_evt;
      else if (err_evt) parity_err <= 1'b1;
   end

`ifdef SERIAL_PARITY_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   sat_counter #(
      .WIDTH (CNT_WIDTH),
      .EN    (CNT_EN)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_err),
      .inc   (err_evt),
      .count (err_count)
   );

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: an 8-bit instance for most frames and a
// 7-bit instance for the no-parity frame; honours SERIAL_PARITY_ERR_CNT_EN.
module tb_serial_parity_checker;
   import uart_parity_pkg::*;

`ifdef SERIAL_PARITY_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk, rst_n, clr_err;
   logic       start, bit_valid, bit_in;
   logic [1:0] parity_mode;
   logic       busy, result_valid, calc_parity, parity_ok, parity_err;
   logic [7:0] data_out, err_count;

   logic       start7, bit_valid7, bit_in7;
   logic [1:0] mode7;
   logic       busy7, result_valid7, calc_parity7, parity_ok7, parity_err7;
   logic [6:0] data_out7;
   logic [7:0] err_count7;
   logic [6:0] d7;

   int checks = 0;
   int errors = 0;

   serial_parity_checker #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .parity_mode(parity_mode),
      .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy), .result_valid(result_valid),
      .data_out(data_out), .calc_parity(calc_parity), .parity_ok(parity_ok),
      .parity_err(parity_err), .clr_err(clr_err), .err_count(err_count)
   );

   serial_parity_checker #(.DATA_WIDTH(7), .CNT_WIDTH(8)) dut7 (
      .clk(clk), .rst_n(rst_n), .start(start7), .parity_mode(mode7),
      .bit_valid(bit_valid7), .bit_in(bit_in7), .busy(busy7), .result_valid(result_valid7),
      .data_out(data_out7), .calc_parity(calc_parity7), .parity_ok(parity_ok7),
      .parity_err(parity_err7), .clr_err(clr_err), .err_count(err_count7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pulse(input logic [1:0] m);
      start       = 1'b1;
      parity_mode = m;
      tick();
      start = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      bit_valid = 1'b1;
      bit_in    = b;
      tick();
      bit_valid = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) send_bit(d[i]);
   endtask

   task automatic frame8(input logic [1:0] m, input logic [7:0] d, input logic par);
      start_pulse(m);
      send_bits(d, 8);
      if (m != PAR_NONE) send_bit(par);
   endtask

   initial begin
      rst_n = 1'b0; clr_err = 1'b0;
      start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; parity_mode = PAR_NONE;
      start7 = 1'b0; bit_valid7 = 1'b0; bit_in7 = 1'b0; mode7 = PAR_NONE;
      d7 = 7'h55;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_calc_parity", calc_parity, 0);
      check("rst_parity_ok", parity_ok, 1);
      check("rst_parity_err", parity_err, 0);
      check("rst_err_count", err_count, 0);
      rst_n = 1'b1;
      tick();

      // even, 0x0F, correct parity 0
      start_pulse(PAR_EVEN);
      check("even_busy", busy, 1);
      send_bits(8'h0F, 8);
      check("even_no_rv_before_parity", result_valid, 0);
      check("even_busy_in_parity", busy, 1);
      send_bit(1'b0);
      check("even_rv", result_valid, 1);
      check("even_busy_done", busy, 0);
      check("even_data", data_out, 8'h0F);
      check("even_calc", calc_parity, 0);
      check("even_ok", parity_ok, 1);
      tick();
      check("even_rv_pulse", result_valid, 0);
      check("even_data_held", data_out, 8'h0F);
      check("even_err", parity_err, 0);
      check("even_cnt", err_count, 0);

      // odd, 0x01, wrong parity 1
      frame8(PAR_ODD, 8'h01, 1'b1);
      check("odd_rv", result_valid, 1);
      check("odd_calc", calc_parity, 0);
      check("odd_ok", parity_ok, 0);
      tick();
      check("odd_err", parity_err, 1);
      check("odd_cnt", err_count, CNT_EN ? 1 : 0);

      // none mode on the 7-bit instance
      start7 = 1'b1; mode7 = PAR_NONE;
      tick();
      start7 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bit_valid7 = 1'b1;
         bit_in7    = d7[i];
         if (i == 6) check("none7_no_rv_early", result_valid7, 0);
         tick();
      end
      bit_valid7 = 1'b0;
      check("none7_rv", result_valid7, 1);
      check("none7_data", data_out7, 7'h55);
      check("none7_calc", calc_parity7, 0);
      check("none7_ok", parity_ok7, 1);
      tick();
      check("none7_idle", busy7, 0);

      // mark, 0xFF, parity 0 -> error; repeat to saturate
      frame8(PAR_MARK, 8'hFF, 1'b0);
      check("mark_calc", calc_parity, 1);
      check("mark_ok", parity_ok, 0);
      tick();
      check("mark_cnt", err_count, CNT_EN ? 2 : 0);
      for (int r = 0; r < 299; r++) begin
         frame8(PAR_MARK, 8'hFF, 1'b0);
         tick();
      end
      check("mark_saturated", err_count, CNT_EN ? 255 : 0);
      check("mark_err_sticky", parity_err, 1);

      // clear coincident with a further error
      clr_err = 1'b1;
      frame8(PAR_MARK, 8'hFF, 1'b0);
      tick();
      clr_err = 1'b0;
      check("clr_coincident_cnt", err_count, CNT_EN ? 1 : 0);
      check("clr_coincident_err", parity_err, 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_only_cnt", err_count, 0);
      check("clr_only_err", parity_err, 0);

      // abort after 4 bits with a coincident bit; mode change mid-frame ignored
      start_pulse(PAR_EVEN);
      send_bits(8'h0F, 4);
      start = 1'b1; parity_mode = PAR_EVEN; bit_valid = 1'b1; bit_in = 1'b1;
      tick();
      start = 1'b0; bit_valid = 1'b0;
      parity_mode = PAR_ODD;
      check("abort_no_rv", result_valid, 0);
      check("abort_busy", busy, 1);
      send_bits(8'hA5, 8);
      check("abort_no_rv_before_parity", result_valid, 0);
      send_bit(1'b0);
      check("abort_rv", result_valid, 1);
      check("abort_data", data_out, 8'hA5);
      check("abort_calc", calc_parity, 0);
      check("abort_ok", parity_ok, 1);

      // start honoured in the DONE cycle
      start_pulse(PAR_EVEN);
      check("done_start_busy", busy, 1);
      check("done_start_no_rv", result_valid, 0);
      send_bits(8'h01, 8);
      send_bit(1'b0);
      check("done_start_rv", result_valid, 1);
      check("done_start_data", data_out, 8'h01);
      check("done_start_calc", calc_parity, 1);
      check("done_start_ok", parity_ok, 0);
      tick();
      check("abort_no_extra_err_cnt", err_count, CNT_EN ? 1 : 0);

      // reset mid-PARITY
      start_pulse(PAR_EVEN);
      send_bits(8'hFF, 8);
      check("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_rv", result_valid, 0);
      check("midrst_data", data_out, 0);
      check("midrst_calc", calc_parity, 0);
      check("midrst_ok", parity_ok, 1);
      check("midrst_err", parity_err, 0);
      check("midrst_cnt", err_count, 0);
      tick();
      rst_n = 1'b1;
      tick();
      frame8(PAR_EVEN, 8'h3C, 1'b0);
      check("post_rst_rv", result_valid, 1);
      check("post_rst_data", data_out, 8'h3C);
      check("post_rst_ok", parity_ok, 1);
      check("post_rst_calc", calc_parity, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
